// File: rtl/fpnew_issue_ctrl.sv
// Core-side issue controller for the FPU handshake.
// Allocates tags from a small pool, issues requests to the FPU, collects
// out-of-order results by tag into a single registered writeback slot, and
// stalls requests whose source or destination register is still in flight.
module fpnew_issue_ctrl #(
    parameter int unsigned Width        = 64,
    parameter int unsigned NumOperands  = 3,
    parameter int unsigned CtrlWidth    = 16,
    parameter int unsigned NumTags      = 4,
    parameter int unsigned TagWidth     = $clog2(NumTags),
    parameter int unsigned RegAddrWidth = 5
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    // Core request
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [NumOperands*Width-1:0]        req_operands_i,
    input  logic [NumOperands*RegAddrWidth-1:0] req_rs_addr_i,
    input  logic [NumOperands-1:0]              req_rs_used_i,
    input  logic [RegAddrWidth-1:0]             req_rd_addr_i,
    input  logic [CtrlWidth-1:0]                req_ctrl_i,
    // FPU request side
    output logic                                fpu_valid_o,
    input  logic                                fpu_ready_i,
    output logic [NumOperands*Width-1:0]        fpu_operands_o,
    output logic [CtrlWidth-1:0]                fpu_ctrl_o,
    output logic [TagWidth-1:0]                 fpu_tag_o,
    output logic                                fpu_flush_o,
    // FPU result side
    input  logic                                fpu_out_valid_i,
    output logic                                fpu_out_ready_o,
    input  logic [Width-1:0]                    fpu_result_i,
    input  logic [4:0]                          fpu_status_i,
    input  logic [TagWidth-1:0]                 fpu_tag_i,
    // Core writeback
    output logic                                wb_valid_o,
    input  logic                                wb_ready_i,
    output logic [RegAddrWidth-1:0]             wb_rd_addr_o,
    output logic [Width-1:0]                    wb_result_o,
    output logic [4:0]                          wb_status_o,
    // Status
    output logic                                busy_o,
    output logic [TagWidth:0]                   outstanding_o
);

    // Tag pool state
    logic [NumTags-1:0]      busy_q, busy_d;
    logic [RegAddrWidth-1:0] rd_q [NumTags];
    logic [RegAddrWidth-1:0] rd_d [NumTags];

    // Writeback register
    logic                    wb_valid_q, wb_valid_d;
    logic [RegAddrWidth-1:0] wb_rd_q, wb_rd_d;
    logic [Width-1:0]        wb_result_q, wb_result_d;
    logic [4:0]              wb_status_q, wb_status_d;

    logic                    free_avail;
    logic [TagWidth-1:0]     free_tag;
    logic                    hazard;
    logic                    go;
    logic                    alloc;
    logic                    ret;
    logic                    ret_hit;
    logic [TagWidth:0]       busy_cnt;

    // Lowest-index free tag from the registered busy vector
    always_comb begin
        free_avail = 1'b0;
        free_tag   = '0;
        for (int i = NumTags - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_avail = 1'b1;
                free_tag   = TagWidth'(i);
            end
        end
    end

    // RAW/WAW hazard against every destination still owed to the core
    always_comb begin
        hazard = 1'b0;
        for (int t = 0; t < NumTags; t++) begin
            if (busy_q[t]) begin
                if (req_rd_addr_i == rd_q[t]) hazard = 1'b1;
                for (int k = 0; k < NumOperands; k++) begin
                    if (req_rs_used_i[k] &&
                        req_rs_addr_i[k*RegAddrWidth +: RegAddrWidth] == rd_q[t]) begin
                        hazard = 1'b1;
                    end
                end
            end
        end
        // A result parked in the writeback slot is not yet architecturally visible
        if (wb_valid_q) begin
            if (req_rd_addr_i == wb_rd_q) hazard = 1'b1;
            for (int k = 0; k < NumOperands; k++) begin
                if (req_rs_used_i[k] &&
                    req_rs_addr_i[k*RegAddrWidth +: RegAddrWidth] == wb_rd_q) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // Issue handshake; fpu_valid_o is kept independent of fpu_ready_i
    always_comb begin
        go             = req_valid_i & free_avail & ~hazard & ~flush_i;
        fpu_valid_o    = go;
        req_ready_o    = go & fpu_ready_i;
        alloc          = go & fpu_ready_i;
        fpu_operands_o = req_operands_i;
        fpu_ctrl_o     = req_ctrl_i;
        fpu_tag_o      = free_tag;
        fpu_flush_o    = flush_i;
    end

    // Result acceptance; unknown tags and flush-cycle results are swallowed
    always_comb begin
        fpu_out_ready_o = ~wb_valid_q | wb_ready_i;
        ret             = fpu_out_valid_i & fpu_out_ready_o;
        ret_hit         = ret & busy_q[fpu_tag_i] & ~flush_i;
    end

    // Next-state for tag pool and writeback slot
    always_comb begin
        busy_d      = busy_q;
        rd_d        = rd_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_result_d = wb_result_q;
        wb_status_d = wb_status_q;
        if (flush_i) begin
            busy_d     = '0;
            wb_valid_d = 1'b0;
        end else begin
            if (wb_valid_q && wb_ready_i) wb_valid_d = 1'b0;
            if (ret_hit) begin
                busy_d[fpu_tag_i] = 1'b0;
                wb_valid_d        = 1'b1;
                wb_rd_d           = rd_q[fpu_tag_i];
                wb_result_d       = fpu_result_i;
                wb_status_d       = fpu_status_i;
            end
            // The allocated tag was free pre-edge, so it never collides with ret_hit
            if (alloc) begin
                busy_d[free_tag] = 1'b1;
                rd_d[free_tag]   = req_rd_addr_i;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q      <= '0;
            for (int i = 0; i < NumTags; i++) rd_q[i] <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_result_q <= '0;
            wb_status_q <= '0;
        end else begin
            busy_q      <= busy_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_result_q <= wb_result_d;
            wb_status_q <= wb_status_d;
        end
    end

    // Occupancy count
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NumTags; i++) begin
            if (busy_q[i]) busy_cnt = busy_cnt + (TagWidth+1)'(1);
        end
    end

    // Status and writeback outputs
    always_comb begin
        wb_valid_o    = wb_valid_q;
        wb_rd_addr_o  = wb_rd_q;
        wb_result_o   = wb_result_q;
        wb_status_o   = wb_status_q;
        outstanding_o = busy_cnt;
        busy_o        = (|busy_q) | wb_valid_q;
    end

endmodule

// File: tb/tb_fpnew_issue_ctrl.sv
// Randomized bench for fpnew_issue_ctrl with a register-scoreboard model.
module tb_fpnew_issue_ctrl;

    localparam int W  = 64;
    localparam int N  = 3;
    localparam int C  = 16;
    localparam int T  = 4;
    localparam int TW = 2;
    localparam int R  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [N*W-1:0]  req_operands;
    logic [N*R-1:0]  req_rs_addr;
    logic [N-1:0]    req_rs_used;
    logic [R-1:0]    req_rd_addr;
    logic [C-1:0]    req_ctrl;
    logic            fpu_valid;
    logic            fpu_ready;
    logic [N*W-1:0]  fpu_operands;
    logic [C-1:0]    fpu_ctrl;
    logic [TW-1:0]   fpu_tag;
    logic            fpu_flush;
    logic            fpu_out_valid;
    logic            fpu_out_ready;
    logic [W-1:0]    fpu_result;
    logic [4:0]      fpu_status;
    logic [TW-1:0]   fpu_tag_in;
    logic            wb_valid;
    logic            wb_ready;
    logic [R-1:0]    wb_rd_addr;
    logic [W-1:0]    wb_result;
    logic [4:0]      wb_status;
    logic            busy;
    logic [TW:0]     outstanding;

    fpnew_issue_ctrl #(
        .Width(W), .NumOperands(N), .CtrlWidth(C), .NumTags(T), .TagWidth(TW), .RegAddrWidth(R)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
        .req_rs_addr_i(req_rs_addr), .req_rs_used_i(req_rs_used), .req_rd_addr_i(req_rd_addr),
        .req_ctrl_i(req_ctrl),
        .fpu_valid_o(fpu_valid), .fpu_ready_i(fpu_ready), .fpu_operands_o(fpu_operands),
        .fpu_ctrl_o(fpu_ctrl), .fpu_tag_o(fpu_tag), .fpu_flush_o(fpu_flush),
        .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
        .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_addr_o(wb_rd_addr),
        .wb_result_o(wb_result), .wb_status_o(wb_status),
        .busy_o(busy), .outstanding_o(outstanding)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [N*W-1:0] act,
                             input logic [N*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: which tags hold an operation and for which register,
    // plus the single pending writeback.
    bit         m_busy [T];
    int         m_rd   [T];
    bit         m_wbv;
    int         m_wbrd;
    logic [W-1:0] m_wbres;
    logic [4:0] m_wbst;

    task automatic model_clear();
        for (int i = 0; i < T; i++) m_busy[i] = 0;
        m_wbv = 0;
    endtask

    task automatic set_idle();
        flush = 0; req_valid = 0; req_operands = '0; req_rs_addr = '0; req_rs_used = '0;
        req_rd_addr = '0; req_ctrl = '0; fpu_ready = 1; fpu_out_valid = 0; fpu_result = '0;
        fpu_status = '0; fpu_tag_in = '0; wb_ready = 1;
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic step();
        bit pending [32];
        int exp_tag, cnt;
        bit avail, haz, go, fire, acc, oready;
        #1;
        avail = 0; exp_tag = 0; cnt = 0;
        for (int i = T - 1; i >= 0; i--) if (!m_busy[i]) begin avail = 1; exp_tag = i; end
        for (int r = 0; r < 32; r++) pending[r] = 0;
        for (int i = 0; i < T; i++) if (m_busy[i]) begin pending[m_rd[i]] = 1; cnt++; end
        if (m_wbv) pending[m_wbrd] = 1;
        haz = pending[req_rd_addr];
        for (int k = 0; k < N; k++)
            if (req_rs_used[k] && pending[req_rs_addr[k*R +: R]]) haz = 1;
        go     = req_valid && avail && !haz && !flush;
        fire   = go && fpu_ready;
        oready = !m_wbv || wb_ready;
        acc    = fpu_out_valid && oready;

        check_val("fpu_valid", fpu_valid, go);
        check_val("req_ready", req_ready, fire);
        if (go) check_val("fpu_tag", fpu_tag, exp_tag);
        check_val("fpu_flush", fpu_flush, flush);
        check_val("operands", fpu_operands, req_operands);
        check_val("ctrl", fpu_ctrl, req_ctrl);
        check_val("out_ready", fpu_out_ready, oready);
        check_val("wb_valid", wb_valid, m_wbv);
        if (m_wbv) begin
            check_val("wb_rd", wb_rd_addr, m_wbrd);
            check_val("wb_result", wb_result, m_wbres);
            check_val("wb_status", wb_status, m_wbst);
        end
        check_val("outstanding", outstanding, cnt);
        check_val("busy", busy, (cnt != 0) || m_wbv);

        if (flush) begin
            model_clear();
        end else begin
            if (m_wbv && wb_ready) m_wbv = 0;
            if (acc && m_busy[fpu_tag_in]) begin
                m_busy[fpu_tag_in] = 0;
                m_wbv = 1; m_wbrd = m_rd[fpu_tag_in];
                m_wbres = fpu_result; m_wbst = fpu_status;
            end
            if (fire) begin
                m_busy[exp_tag] = 1;
                m_rd[exp_tag]   = req_rd_addr;
            end
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        set_idle();
        model_clear();
        rst = 1;
        #12;
        check_val("rst_wb_valid", wb_valid, 1'b0);
        check_val("rst_outstanding", outstanding, 0);
        check_val("rst_busy", busy, 1'b0);
        rst = 0;
        @(posedge clk); #2;

        // Single op: rd=3, result returned two cycles later on tag 0
        req_valid = 1; req_rd_addr = 3;
        #1; check_val("single_tag", fpu_tag, 0);
        step();
        req_valid = 0;
        check_val("single_out1", outstanding, 1);
        step();
        step();
        fpu_out_valid = 1; fpu_tag_in = 0; fpu_result = 64'h3FF0000000000000; fpu_status = 5'h01;
        step();
        fpu_out_valid = 0;
        #1;
        check_val("single_wbv", wb_valid, 1'b1);
        check_val("single_wbrd", wb_rd_addr, 3);
        check_val("single_wbres", wb_result, 64'h3FF0000000000000);
        check_val("single_out0", outstanding, 0);
        step();

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 3000; c++) begin
            req_valid    = ($urandom_range(0, 3) != 0);
            req_operands = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < N; k++) req_rs_addr[k*R +: R] = R'($urandom_range(0, 9));
            req_rs_used  = N'($urandom);
            req_rd_addr  = R'($urandom_range(0, 9));
            req_ctrl     = C'($urandom);
            fpu_ready    = ($urandom_range(0, 3) != 0);
            fpu_out_valid = $urandom_range(0, 1) == 1;
            fpu_tag_in   = TW'($urandom);
            fpu_result   = {$urandom, $urandom};
            fpu_status   = 5'($urandom);
            wb_ready     = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 39) == 0);
            step();
        end

        // Asynchronous reset in the middle of a cycle with work in flight
        set_idle();
        req_valid = 1; req_rd_addr = 11; step();
        req_rd_addr = 12; step();
        req_valid = 0;
        #1;
        rst = 1;
        #1;
        check_val("arst_outstanding", outstanding, 0);
        check_val("arst_wb_valid", wb_valid, 1'b0);
        check_val("arst_busy", busy, 1'b0);
        model_clear();
        rst = 0;
        step();
        // Stale result after reset must be dropped
        fpu_out_valid = 1; fpu_tag_in = 1; fpu_result = 64'h1234;
        step();
        fpu_out_valid = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
